// File: rtl/ex_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_pkg
// Purpose  : Shared definitions for the EX/MEM pipeline boundary: FSM state
//            encoding of the two-entry output buffer, the default datapath
//            width, ALU operation codes shared with the ALU and its control,
//            and the branch-resolution helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ex_mem_stage_pkg;

   // Occupancy of the head/skid buffer.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam int c_XLEN_DEFAULT = 32;

   // ALU operation codes.
   localparam logic [3:0] c_ALUOP_AND = 4'b0000;
   localparam logic [3:0] c_ALUOP_OR  = 4'b0001;
   localparam logic [3:0] c_ALUOP_ADD = 4'b0010;
   localparam logic [3:0] c_ALUOP_SUB = 4'b0110;

   // beq is taken on zero, bne on non-zero; XOR with branch_ne covers both.
   function automatic logic branch_taken(input logic i_branch,
                                         input logic i_branch_ne,
                                         input logic i_alu_zero);
      return i_branch & (i_alu_zero ^ i_branch_ne);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_if
// Purpose  : Bundles the upstream (ALU) handshake, the downstream (memory
//            stage) handshake and the branch redirect/statistics outputs of
//            the EX/MEM stage.
// Modports : master - environment side (drives in_*, out_ready, flush)
//            slave  - the ex_mem_stage itself
// Revision : 1.0 - initial release
// ============================================================================
interface ex_mem_stage_if
   import ex_mem_stage_pkg::*;
#(
   parameter int XLEN  = c_XLEN_DEFAULT,
   parameter int CNT_W = 16
);
   // Upstream side
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  alu_result;
   logic             alu_zero;
   logic [4:0]       rd;
   logic             reg_write;
   logic             mem_read;
   logic             mem_write;
   logic             branch;
   logic             branch_ne;
   logic [XLEN-1:0]  store_data;
   logic [XLEN-1:0]  br_target;
   logic             flush;
   // Downstream side
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [XLEN-1:0]  out_store_data;
   logic [4:0]       out_rd;
   logic             out_reg_write;
   logic             out_mem_read;
   logic             out_mem_write;
   // Redirect and statistics
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] taken_count;

   modport master (
      output in_valid, alu_result, alu_zero, rd, reg_write, mem_read,
             mem_write, branch, branch_ne, store_data, br_target, flush,
             out_ready,
      input  in_ready, out_valid, out_result, out_store_data, out_rd,
             out_reg_write, out_mem_read, out_mem_write, redirect_valid,
             redirect_pc, taken_count
   );

   modport slave (
      input  in_valid, alu_result, alu_zero, rd, reg_write, mem_read,
             mem_write, branch, branch_ne, store_data, br_target, flush,
             out_ready,
      output in_ready, out_valid, out_result, out_store_data, out_rd,
             out_reg_write, out_mem_read, out_mem_write, redirect_valid,
             redirect_pc, taken_count
   );

endinterface
`default_nettype wire

// File: rtl/ex_mem_entry_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_entry_reg
// Purpose  : Loadable register holding one packed EX/MEM buffer entry.
//            Cleared by reset, otherwise holds unless i_load is asserted.
// Ports    : clk, rst_n (sync, active-low), i_load, i_d[W], o_q[W]
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_entry_reg #(
   parameter int W = 8
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         i_load,
   input  wire logic [W-1:0] i_d,
   output logic      [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX/MEM pipeline boundary with a two-entry (head + skid) buffer,
//            branch resolution with a one-cycle redirect pulse, and a
//            saturating taken-branch counter.
// Ports    : clk            - clock
//            rst_n          - synchronous active-low reset
//            bus (slave)    - upstream/downstream handshakes, entry fields,
//                             flush, redirect and taken_count
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int XLEN  = c_XLEN_DEFAULT,
   parameter int CNT_W = 16
) (
   input wire logic      clk,
   input wire logic      rst_n,
   ex_mem_stage_if.slave bus
);

   // Packed entry: {reg_write, mem_read, mem_write, rd, store_data, result}
   localparam int c_ENTRY_W = 2*XLEN + 8;
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   state_t              r_state;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_redirect_valid;
   logic [XLEN-1:0]     r_redirect_pc;
   logic [CNT_W-1:0]    r_taken_count;

   logic                w_push;
   logic                w_pop;
   logic                w_taken;
   logic                w_head_load;
   logic                w_skid_load;
   logic [c_ENTRY_W-1:0] w_in_entry;
   logic [c_ENTRY_W-1:0] w_head_d;
   logic [c_ENTRY_W-1:0] w_head_q;
   logic [c_ENTRY_W-1:0] w_skid_q;

   assign w_in_entry = {bus.reg_write, bus.mem_read, bus.mem_write, bus.rd,
                        bus.store_data, bus.alu_result};

   assign w_push  = bus.in_valid & r_in_ready;
   assign w_pop   = r_out_valid & bus.out_ready;
   // Flush wins over a same-cycle push, so its branch effects vanish too.
   assign w_taken = w_push & ~bus.flush &
                    branch_taken(bus.branch, bus.branch_ne, bus.alu_zero);

   // Head takes new data when it is (or becomes) the only slot in use, or
   // the skid entry when draining from FULL.
   assign w_head_load = ~bus.flush &
                        (((r_state == ST_EMPTY) & w_push) |
                         ((r_state == ST_ONE)   & w_push & w_pop) |
                         ((r_state == ST_FULL)  & w_pop));
   assign w_skid_load = ~bus.flush & (r_state == ST_ONE) & w_push & ~w_pop;
   assign w_head_d    = (r_state == ST_FULL) ? w_skid_q : w_in_entry;

   ex_mem_entry_reg #(.W(c_ENTRY_W)) u_head (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_head_load),
      .i_d    (w_head_d),
      .o_q    (w_head_q)
   );

   ex_mem_entry_reg #(.W(c_ENTRY_W)) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_skid_load),
      .i_d    (w_in_entry),
      .o_q    (w_skid_q)
   );

   // Occupancy FSM with registered handshake, redirect and counter outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= ST_EMPTY;
         r_in_ready       <= 1'b1;
         r_out_valid      <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_taken_count    <= '0;
      end else begin
         r_redirect_valid <= w_taken;
         if (w_taken) begin
            r_redirect_pc <= bus.br_target;
            if (r_taken_count != c_CNT_MAX) begin
               r_taken_count <= r_taken_count + 1'b1;
            end
         end

         if (bus.flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
         end else begin
            case (r_state)
               ST_EMPTY: begin
                  if (w_push) begin
                     r_state     <= ST_ONE;
                     r_out_valid <= 1'b1;
                  end
               end
               ST_ONE: begin
                  if (w_push && !w_pop) begin
                     r_state    <= ST_FULL;
                     r_in_ready <= 1'b0;
                  end else if (!w_push && w_pop) begin
                     r_state     <= ST_EMPTY;
                     r_out_valid <= 1'b0;
                  end
               end
               ST_FULL: begin
                  if (w_pop) begin
                     r_state    <= ST_ONE;
                     r_in_ready <= 1'b1;
                  end
               end
               default: begin
                  r_state     <= ST_EMPTY;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.in_ready       = r_in_ready;
   assign bus.out_valid      = r_out_valid;
   assign bus.out_result     = w_head_q[XLEN-1:0];
   assign bus.out_store_data = w_head_q[2*XLEN-1:XLEN];
   assign bus.out_rd         = w_head_q[2*XLEN+4:2*XLEN];
   assign bus.out_mem_write  = w_head_q[2*XLEN+5];
   assign bus.out_mem_read   = w_head_q[2*XLEN+6];
   assign bus.out_reg_write  = w_head_q[2*XLEN+7];
   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;
   assign bus.taken_count    = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Self-checking bench for ex_mem_stage. A queue-based model of a
//            two-deep FIFO with branch bookkeeping predicts every output;
//            directed scenarios add literal expectations, then random
//            traffic with sporadic flush and reset follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic [31:0] res;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;

   ex_mem_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   ex_mem_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   ent_t        m_q[$];
   bit          m_rv;
   logic [31:0] m_rpc;
   int          m_cnt;
   bit          m_known = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock: model consumes the current inputs, then the edge.
   task automatic tick();
      ent_t e;
      bit   push, pop, tk;
      if (!rst_n) begin
         m_q.delete();
         m_rv    = 1'b0;
         m_rpc   = '0;
         m_cnt   = 0;
         m_known = 1'b1;
      end else if (bus.flush) begin
         m_q.delete();
         m_rv = 1'b0;
      end else begin
         pop  = (m_q.size() > 0) && bus.out_ready;
         push = bus.in_valid && (m_q.size() < 2);
         if (pop) void'(m_q.pop_front());
         if (push) begin
            e.res = bus.alu_result; e.sd = bus.store_data; e.rd = bus.rd;
            e.rw = bus.reg_write;   e.mr = bus.mem_read;   e.mw = bus.mem_write;
            m_q.push_back(e);
         end
         tk   = push && bus.branch && (bus.alu_zero != bus.branch_ne);
         m_rv = tk;
         if (tk) begin
            m_rpc = bus.br_target;
            if (m_cnt < CNT_MAX) m_cnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Compare DUT against the model every cycle once the model is defined.
   always @(negedge clk) begin
      if (m_known) begin
         chk("in_ready", bus.in_ready, m_q.size() < 2);
         chk("out_valid", bus.out_valid, m_q.size() > 0);
         if (m_q.size() > 0) begin
            chk("out_result", bus.out_result, m_q[0].res);
            chk("out_store_data", bus.out_store_data, m_q[0].sd);
            chk("out_rd", bus.out_rd, m_q[0].rd);
            chk("out_reg_write", bus.out_reg_write, m_q[0].rw);
            chk("out_mem_read", bus.out_mem_read, m_q[0].mr);
            chk("out_mem_write", bus.out_mem_write, m_q[0].mw);
         end
         chk("redirect_valid", bus.redirect_valid, m_rv);
         chk("redirect_pc", bus.redirect_pc, m_rpc);
         chk("taken_count", bus.taken_count, m_cnt);
      end
   end

   task automatic idle();
      bus.in_valid = 0; bus.alu_result = '0; bus.alu_zero = 0; bus.rd = '0;
      bus.reg_write = 0; bus.mem_read = 0; bus.mem_write = 0;
      bus.branch = 0; bus.branch_ne = 0; bus.store_data = '0;
      bus.br_target = '0; bus.flush = 0;
   endtask

   task automatic put(input logic [31:0] res, input logic [4:0] rd,
                      input logic br, input logic ne, input logic zero,
                      input logic [31:0] tgt);
      bus.in_valid = 1; bus.alu_result = res; bus.rd = rd;
      bus.reg_write = ~br; bus.mem_read = 0; bus.mem_write = 0;
      bus.branch = br; bus.branch_ne = ne; bus.alu_zero = zero;
      bus.store_data = res ^ 32'h5A5A_0000; bus.br_target = tgt;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      idle();
      @(negedge clk);
      #1;

      // Reset state, with inputs active that must be ignored
      put(32'hDEAD_BEEF, 5'd7, 1, 0, 1, 32'h44);
      bus.out_ready = 1;
      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_redirect_valid", bus.redirect_valid, 0);
      chk("rst_redirect_pc", bus.redirect_pc, 0);
      chk("rst_taken_count", bus.taken_count, 0);
      chk("rst_out_result", bus.out_result, 0);
      chk("rst_out_rd", bus.out_rd, 0);

      // Single push, one-cycle latency
      rst_n = 1'b1;
      idle();
      put(32'h0000_0005, 5'd3, 0, 0, 0, 0);
      bus.out_ready = 1;
      tick();
      idle();
      chk("lat_out_valid", bus.out_valid, 1);
      chk("lat_out_result", bus.out_result, 32'h5);
      chk("lat_out_rd", bus.out_rd, 3);
      chk("lat_out_reg_write", bus.out_reg_write, 1);
      tick();
      chk("lat_drain_out_valid", bus.out_valid, 0);

      // Back-pressure with A, B, C
      bus.out_ready = 0;
      put(32'hA, 5'd1, 0, 0, 0, 0);
      tick();
      chk("bp_head_A", bus.out_result, 32'hA);
      put(32'hB, 5'd2, 0, 0, 0, 0);
      tick();
      chk("bp_full_in_ready", bus.in_ready, 0);
      put(32'hC, 5'd3, 0, 0, 0, 0);
      tick();
      chk("bp_hold_in_ready", bus.in_ready, 0);
      chk("bp_hold_A", bus.out_result, 32'hA);
      bus.out_ready = 1;
      tick();
      chk("bp_order_B", bus.out_result, 32'hB);
      tick();
      chk("bp_order_C", bus.out_result, 32'hC);
      idle();
      tick();
      chk("bp_empty", bus.out_valid, 0);

      // beq taken, bne not taken
      put(32'h0, 5'd0, 1, 0, 1, 32'h100);
      tick();
      idle();
      chk("beq_redirect", bus.redirect_valid, 1);
      chk("beq_pc", bus.redirect_pc, 32'h100);
      tick();
      chk("beq_pulse_end", bus.redirect_valid, 0);
      put(32'h0, 5'd0, 1, 1, 1, 32'h200);
      tick();
      idle();
      chk("bne_no_redirect", bus.redirect_valid, 0);
      chk("br_count", bus.taken_count, 1);
      tick();

      // Flush while FULL with a taken branch presented
      bus.out_ready = 0;
      put(32'h11, 5'd4, 0, 0, 0, 0);
      tick();
      put(32'h22, 5'd5, 0, 0, 0, 0);
      tick();
      put(32'h0, 5'd0, 1, 0, 1, 32'h300);
      bus.flush = 1;
      tick();
      idle();
      chk("flush_full_out_valid", bus.out_valid, 0);
      chk("flush_full_in_ready", bus.in_ready, 1);
      chk("flush_full_redirect", bus.redirect_valid, 0);
      chk("flush_full_count", bus.taken_count, 1);
      // Flush in ONE dropping an acceptable taken push
      put(32'h33, 5'd6, 0, 0, 0, 0);
      tick();
      put(32'h0, 5'd0, 1, 0, 1, 32'h400);
      bus.flush = 1;
      tick();
      idle();
      chk("flush_one_out_valid", bus.out_valid, 0);
      chk("flush_one_redirect", bus.redirect_valid, 0);
      chk("flush_one_count", bus.taken_count, 1);
      chk("flush_one_pc", bus.redirect_pc, 32'h100);

      // Saturation with CNT_W=2
      rst_n = 0;
      tick();
      rst_n = 1;
      bus.out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         put(32'h0, 5'd0, 1, 1, 0, 32'h500 + i);
         tick();
         chk("sat_count", bus.taken_count, (i < 3) ? i + 1 : 3);
      end
      idle();
      tick();

      // Reset while FULL with a redirect pending
      bus.out_ready = 0;
      put(32'h44, 5'd8, 0, 0, 0, 0);
      tick();
      put(32'h0, 5'd0, 1, 0, 1, 32'h600);
      tick();
      chk("rstfull_pulse", bus.redirect_valid, 1);
      put(32'h0, 5'd0, 1, 0, 1, 32'h700);
      rst_n = 0;
      tick();
      chk("rstfull_redirect", bus.redirect_valid, 0);
      chk("rstfull_out_valid", bus.out_valid, 0);
      chk("rstfull_in_ready", bus.in_ready, 1);
      chk("rstfull_count", bus.taken_count, 0);
      rst_n = 1;
      idle();
      tick();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rst_n          = ($urandom_range(0, 199) != 0);
         bus.flush      = ($urandom_range(0, 24) == 0);
         bus.in_valid   = ($urandom_range(0, 9) < 7);
         bus.out_ready  = ($urandom_range(0, 9) < 6);
         bus.alu_result = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         bus.alu_zero   = $urandom_range(0, 1);
         bus.rd         = 5'($urandom);
         bus.reg_write  = $urandom_range(0, 1);
         bus.mem_read   = $urandom_range(0, 1);
         bus.mem_write  = $urandom_range(0, 1);
         bus.branch     = ($urandom_range(0, 9) < 4);
         bus.branch_ne  = $urandom_range(0, 1);
         bus.store_data = $urandom;
         bus.br_target  = $urandom;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
